fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined RV32I core. Consumes the Branch resolution from the execute-stage branching unit and the execute-stage jump flag to redirect the PC.
- Owns the PC register, a single-outstanding request/response handshake to instruction memory, a one-entry hold buffer, and the IF/ID pipeline register feeding decode.
- Stall inputs come from the hazard unit. Redirect flushes decode.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hazard unit: suppress new fetch request
- StallD  in  1  hazard unit: hold IF/ID contents
- BranchE  in  1  execute instruction is a conditional branch
- BranchTaken  in  1  branch condition result from branching unit
- JumpE  in  1  execute instruction is JAL/JALR
- PCTargetE  in  XLEN  redirect target from execute
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction word
- PCF  out  XLEN  current fetch PC
- InstrD  out  32  IF/ID instruction
- PCD  out  XLEN  IF/ID PC
- PCPlus4D  out  XLEN  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset values: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, kill=0, state=REQ, hold buffer=NOP_INSTR.
- Reset taken mid-operation discards any outstanding request. A response arriving in REQ or HOLD is ignored.
- Redirect = JumpE | (BranchE & BranchTaken), sampled combinationally. It takes effect at the next edge.
- On redirect: PCF <= {PCTargetE[XLEN-1:2],2'b00}. IF/ID <= bubble (InstrD=NOP_INSTR, ValidD=0). Redirect overrides StallD and StallF.
- imem_req = (state==REQ) & ~StallF. imem_addr = PCF. Both are combinational from registered state.
- State REQ:
  - If imem_req & imem_gnt: reqPC <= PCF, PCF <= PCF+4 (mod 2^XLEN), go to WAIT.
  - If redirect occurs in the same cycle as the grant: go to WAIT with kill <= 1, and PCF takes the target.
- State WAIT, waiting for imem_rvalid:
  - Redirect without rvalid: kill <= 1, stay in WAIT.
  - rvalid with kill=1, or rvalid coinciding with redirect: drop the data, kill <= 0, go to REQ.
  - rvalid, no kill, ~StallD: InstrD <= imem_rdata, PCD <= reqPC, PCPlus4D <= reqPC+4, ValidD <= 1, go to REQ.
  - rvalid, no kill, StallD: hold buffer <= imem_rdata, go to HOLD.
- State HOLD:
  - ~StallD and no redirect: load IF/ID from the hold buffer and reqPC, go to REQ.
  - Redirect: drop the buffer, go to REQ.
  - StallD: stay in HOLD.
- IF/ID update rule:
  - StallD=1 and no redirect: all IF/ID outputs hold.
  - StallD=0 and no instruction delivered this cycle: IF/ID <= bubble.
- At most one request is outstanding. With a 1-cycle memory, steady-state throughput is one instruction per 2 cycles.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.
- imem_rdata is never interpreted. Alignment is enforced only on redirect targets.

Decomposition:
- Package fetch_pkg:
  - state enum {REQ, WAIT, HOLD}
  - NOP_INSTR constant
  - RESET_PC default
- Sub-module if_id_reg: IF/ID register with enable (~StallD), synchronous flush, and reset-to-bubble. It carries InstrD, PCD, PCPlus4D and ValidD.

Test Plan:
- Reset, then 1-cycle memory, always granting, returning PC-derived words, no stalls -> imem_addr sequence 0x0, 0x4, 0x8. Each InstrD appears 1 cycle after its rvalid with PCD=addr and PCPlus4D=addr+4. ValidD alternates 1/0.
- BranchE=1, BranchTaken=1, PCTargetE=0x0000_0102 while in WAIT -> kill set, next response discarded, next imem_addr=0x0000_0100, IF/ID bubble (ValidD=0, InstrD=0x0000_0013).
- BranchE=1, BranchTaken=0 -> no redirect, sequential fetch continues. JumpE=1 with PCTargetE=0x40 in the same cycle as imem_gnt -> stale response dropped, next imem_addr=0x40.
- StallD=1 asserted as rvalid returns 0x00A00093 -> state HOLD, IF/ID unchanged. Release StallD after 3 cycles -> InstrD=0x00A00093 next cycle, ValidD=1.
- StallF=1 for 4 cycles in REQ -> imem_req=0, PCF constant. Release -> request issued with the unchanged PCF.
- Assert reset while in WAIT, then deliver a late rvalid -> all outputs at reset values, response ignored, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall-enable, synchronous flush and reset both produce a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            flush,
  input  logic            load,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    // flush wins over a stalled (disabled) register
    if (flush || (en && !load)) begin
      instr_d   = NOP_INSTR;
      pc_d      = '0;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (en) begin
      instr_d   = instr_i;
      pc_d      = pc_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, one-entry hold buffer, IF/ID.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_C[XLEN-1:0],
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            BranchE,
  input  logic            BranchTaken,
  input  logic            JumpE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [31:0]     hold_q, hold_d;
  logic            kill_q, kill_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            deliver;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] req_pc_plus4;
  logic            tgt_lsb_unused;

  assign redirect       = JumpE | (BranchE & BranchTaken);
  assign redirect_pc    = {PCTargetE[XLEN-1:2], 2'b00};
  assign tgt_lsb_unused = ^PCTargetE[1:0];
  assign req_pc_plus4   = req_pc_q + XLEN'(4);

  assign imem_req  = (state_q == REQ) & ~StallF;
  assign imem_addr = pc_q;
  assign PCF       = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    hold_d        = hold_q;
    kill_d        = kill_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;

    if (redirect) begin
      pc_d = redirect_pc;
    end

    unique case (state_q)
      REQ: begin
        if (imem_req && imem_gnt) begin
          req_pc_d = pc_q;
          state_d  = WAIT;
          // a redirect in the grant cycle poisons the response already in flight
          kill_d   = redirect;
          if (!redirect) begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (!StallD) begin
            deliver = 1'b1;
            state_d = REQ;
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = REQ;
        end else if (!StallD) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          state_d       = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      hold_q   <= NOP_INSTR;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      hold_q   <= hold_d;
      kill_q   <= kill_d;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .en        (~StallD),
    .flush     (redirect),
    .load      (deliver),
    .instr_i   (deliver_instr),
    .pc_i      (req_pc_q),
    .pcplus4_i (req_pc_plus4),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pcplus4_o (PCPlus4D),
    .valid_o   (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, BranchE, BranchTaken, JumpE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exp_t        expq[$];
  logic [31:0] addr_log[$];
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        ov_pending = 1'b0;
  logic [31:0] ov_word = '0;
  logic        held_last = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallD      (StallD),
    .BranchE     (BranchE),
    .BranchTaken (BranchTaken),
    .JumpE       (JumpE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    expq.push_back(e);
  endtask

  // One clock cycle; also models the memory (fixed latency mem_lat after a grant).
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    @(negedge clk);
    fire = imem_req && imem_gnt && !reset;
    a    = imem_addr;
    @(posedge clk);
    #1;
    if (fire) begin
      addr_log.push_back(a);
      pend_addr = a;
      pend_cnt  = mem_lat;
    end
    imem_rvalid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        if (ov_pending) begin
          imem_rdata = ov_word;
          ov_pending = 1'b0;
        end else begin
          imem_rdata = mem_word(pend_addr);
        end
      end
    end
  endtask

  // Monitor: a new IF/ID entry is presented when ValidD is set after an edge that was not stalled.
  always @(negedge clk) begin
    exp_t e;
    if (ValidD === 1'b1 && !held_last) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got InstrD=%h PCD=%h expected none", InstrD, PCD);
      end else begin
        e = expq.pop_front();
        check("mon_instr", InstrD, e.instr);
        check("mon_pcd", PCD, e.pc);
        check("mon_pcplus4", PCPlus4D, e.pc + 32'd4);
      end
    end
    held_last = StallD && !(JumpE || (BranchE && BranchTaken)) && !reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    StallF      = 1'b0;
    StallD      = 1'b0;
    BranchE     = 1'b0;
    BranchTaken = 1'b0;
    JumpE       = 1'b0;
    PCTargetE   = '0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // reset values
    tick();
    tick();
    check("rst_pcf", PCF, 32'h0);
    check("rst_instrd", InstrD, NOP);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pcplus4d", PCPlus4D, 32'h0);
    check("rst_validd", {31'b0, ValidD}, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h1);
    reset = 1'b0;

    // sequential fetch, 1-cycle memory
    push_exp(mem_word(32'h0), 32'h0);
    push_exp(mem_word(32'h4), 32'h4);
    push_exp(mem_word(32'h8), 32'h8);
    addr_log.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("validd_alternate", {31'b0, ValidD}, (i % 2 == 1) ? 32'h1 : 32'h0);
    end
    check("seq_addr0", addr_log[0], 32'h0);
    check("seq_addr1", addr_log[1], 32'h4);
    check("seq_addr2", addr_log[2], 32'h8);

    // taken branch while waiting for a 2-cycle response
    mem_lat = 2;
    addr_log.delete();
    tick();
    BranchE = 1'b1; BranchTaken = 1'b1; PCTargetE = 32'h0000_0102;
    tick();
    BranchE = 1'b0; BranchTaken = 1'b0;
    check("br_pcf", PCF, 32'h100);
    check("br_imem_addr", imem_addr, 32'h100);
    check("br_imem_req_wait", {31'b0, imem_req}, 32'h0);
    check("br_validd", {31'b0, ValidD}, 32'h0);
    check("br_instrd", InstrD, NOP);
    tick();
    check("br_drop_validd", {31'b0, ValidD}, 32'h0);
    push_exp(mem_word(32'h100), 32'h100);
    tick();
    mem_lat = 1;
    tick();
    tick();
    check("br_addr_stale", addr_log[0], 32'hC);
    check("br_addr_target", addr_log[1], 32'h100);
    check("br_target_validd", {31'b0, ValidD}, 32'h1);

    // not-taken branch: sequential continues
    BranchE = 1'b1; BranchTaken = 1'b0;
    push_exp(mem_word(32'h104), 32'h104);
    tick();
    tick();
    BranchE = 1'b0;
    check("nt_pcf", PCF, 32'h108);
    check("nt_pcd", PCD, 32'h104);

    // jump in the grant cycle
    JumpE = 1'b1; PCTargetE = 32'h40;
    tick();
    JumpE = 1'b0;
    check("jmp_pcf", PCF, 32'h40);
    check("jmp_validd", {31'b0, ValidD}, 32'h0);
    tick();
    check("jmp_drop_validd", {31'b0, ValidD}, 32'h0);
    check("jmp_back_in_req", {31'b0, imem_req}, 32'h1);
    push_exp(mem_word(32'h40), 32'h40);
    addr_log.delete();
    tick();
    tick();
    check("jmp_addr", addr_log[0], 32'h40);

    // decode stall while the response returns -> hold buffer
    StallD = 1'b1;
    ov_pending = 1'b1;
    ov_word = 32'h00A0_0093;
    tick();
    tick();
    check("hold_instrd", InstrD, mem_word(32'h40));
    check("hold_pcd", PCD, 32'h40);
    check("hold_validd", {31'b0, ValidD}, 32'h1);
    check("hold_no_req", {31'b0, imem_req}, 32'h0);
    tick();
    tick();
    check("hold_instrd_late", InstrD, mem_word(32'h40));
    check("hold_no_req_late", {31'b0, imem_req}, 32'h0);
    check("hold_pcf", PCF, 32'h48);
    StallD = 1'b0;
    push_exp(32'h00A0_0093, 32'h44);
    tick();
    check("hold_release_instrd", InstrD, 32'h00A0_0093);
    check("hold_release_validd", {31'b0, ValidD}, 32'h1);
    check("hold_release_pcplus4", PCPlus4D, 32'h48);

    // fetch stall in REQ
    StallF = 1'b1;
    addr_log.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stallf_req", {31'b0, imem_req}, 32'h0);
      check("stallf_pcf", PCF, 32'h48);
    end
    StallF = 1'b0;
    push_exp(mem_word(32'h48), 32'h48);
    tick();
    tick();
    check("stallf_count", addr_log.size(), 32'd1);
    check("stallf_addr", addr_log[0], 32'h48);

    // reset while in WAIT, late response afterwards
    mem_lat = 3;
    tick();
    reset = 1'b1;
    tick();
    check("midrst_pcf", PCF, 32'h0);
    check("midrst_instrd", InstrD, NOP);
    check("midrst_pcd", PCD, 32'h0);
    check("midrst_pcplus4d", PCPlus4D, 32'h0);
    check("midrst_validd", {31'b0, ValidD}, 32'h0);
    reset = 1'b0;
    imem_gnt = 1'b0;
    tick();
    tick();
    check("late_validd", {31'b0, ValidD}, 32'h0);
    check("late_instrd", InstrD, NOP);
    check("late_pcf", PCF, 32'h0);
    check("late_imem_addr", imem_addr, 32'h0);
    check("late_imem_req", {31'b0, imem_req}, 32'h1);
    imem_gnt = 1'b1;
    mem_lat = 1;
    push_exp(mem_word(32'h0), 32'h0);
    tick();
    tick();
    check("recover_instrd", InstrD, mem_word(32'h0));

    // misaligned redirect target and PC wrap
    imem_gnt = 1'b0;
    JumpE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    tick();
    JumpE = 1'b0;
    imem_gnt = 1'b1;
    check("wrap_align_pcf", PCF, 32'hFFFF_FFFC);
    push_exp(mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC);
    tick();
    check("wrap_pcf", PCF, 32'h0);
    tick();
    check("wrap_pcplus4d", PCPlus4D, 32'h0);

    tick();
    tick();
    check("scoreboard_drain", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
